// File: rtl/map_table_pkg.sv
`default_nettype none
// ============================================================================
// Module      : map_table_pkg
// Description : Shared types and constants for the register-rename map table.
//               Defines the architectural and physical register tag types, the
//               {register, ready} map entry, table sizes, and the CDB tag-match
//               helper used by both the lookup and update paths.
// Revision    : 1.0 - initial release
// ============================================================================
package map_table_pkg;

  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int WAYS     = 2;

  typedef logic [4:0] ARCH_REG;
  typedef logic [5:0] PHYS_REG;

  typedef struct packed {
    PHYS_REG register;
    logic    ready;
  } PHYS_WITH_READY;

  // Architectural register 31 reads as zero and is never renamed.
  localparam ARCH_REG ZERO_REG = 5'd31;

  // True when any enabled CDB lane is broadcasting the given tag.
  function automatic logic cdb_hit(
    input logic [WAYS-1:0]      en,
    input logic [WAYS-1:0][5:0] rd,
    input PHYS_REG              tag
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      if (en[k] && (rd[k] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage : map_table_pkg
`default_nettype wire

// File: rtl/map_table_mt_lookup.sv
`default_nettype none
// ============================================================================
// Module      : mt_lookup
// Description : Combinational per-slot rename lookup. Produces the source A/B
//               physical tags with ready bits (including same-cycle CDB bypass)
//               and the destination's previous mapping. When FORWARD is set the
//               slot is younger than slot 0 and sees slot 0's new mapping.
// Ports       : map          - full current table
//               rega_idx     - source A architectural register
//               regb_idx     - source B architectural register
//               dest_idx     - this slot's destination register
//               fwd_dest_idx - older slot's destination register
//               fwd_tag      - older slot's newly allocated tag
//               cdb_rd_en    - CDB lane valids
//               cdb_rd       - CDB lane tags
//               tag_a/tag_b  - source tags with ready
//               tag_old      - previous mapping of dest_idx
// Revision    : 1.0 - initial release
// ============================================================================
module mt_lookup
  import map_table_pkg::*;
#(
  parameter bit FORWARD = 1'b0
) (
  input  PHYS_WITH_READY [NUM_ARCH-1:0] map,
  input  logic [4:0]                    rega_idx,
  input  logic [4:0]                    regb_idx,
  input  logic [4:0]                    dest_idx,
  input  logic [4:0]                    fwd_dest_idx,
  input  logic [5:0]                    fwd_tag,
  input  logic [WAYS-1:0]               cdb_rd_en,
  input  logic [WAYS-1:0][5:0]          cdb_rd,
  output PHYS_WITH_READY                tag_a,
  output PHYS_WITH_READY                tag_b,
  output logic [5:0]                    tag_old
);

  PHYS_WITH_READY w_entry_a;
  PHYS_WITH_READY w_entry_b;
  logic           w_fwd_live;

  always_comb begin
    w_fwd_live = FORWARD && (fwd_dest_idx != ZERO_REG);
    w_entry_a  = map[rega_idx];
    w_entry_b  = map[regb_idx];

    tag_a = '{register: w_entry_a.register,
              ready:    w_entry_a.ready | cdb_hit(cdb_rd_en, cdb_rd, w_entry_a.register)};
    tag_b = '{register: w_entry_b.register,
              ready:    w_entry_b.ready | cdb_hit(cdb_rd_en, cdb_rd, w_entry_b.register)};
    tag_old = map[dest_idx].register;

    // The older slot's freshly allocated tag cannot be complete yet.
    if (w_fwd_live && (rega_idx == fwd_dest_idx)) tag_a = '{register: fwd_tag, ready: 1'b0};
    if (w_fwd_live && (regb_idx == fwd_dest_idx)) tag_b = '{register: fwd_tag, ready: 1'b0};
    if (w_fwd_live && (dest_idx == fwd_dest_idx)) tag_old = fwd_tag;
  end

endmodule : mt_lookup
`default_nettype wire

// File: rtl/map_table.sv
`default_nettype none
// ============================================================================
// Module      : map_table
// Description : Register-rename map table for a 2-way R10K-style core. Holds
//               the arch->phys mapping plus ready bit for 32 registers, renames
//               up to two instructions per cycle, sets ready on CDB broadcasts
//               and restores from a branch checkpoint on mispredict.
// Ports       : clk, reset (async, active-low)
//               de_destidx/de_regAidx/de_regBidx - per-slot arch registers
//               fl_freeRegs      - new physical tags per slot
//               haz_nDispatched  - slots dispatching (3 behaves as 2)
//               cdb_rd_en/cdb_rd - completion broadcasts
//               br_fub_pred_wrong/bs_recov_map - mispredict recovery
//               mt_tagA/mt_tagB/mt_dispatchTagOld - rename results
//               map              - full table
// Revision    : 1.0 - initial release
// ============================================================================
module map_table
  import map_table_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WAYS-1:0][4:0]          de_destidx,
  input  logic [WAYS-1:0][4:0]          de_regAidx,
  input  logic [WAYS-1:0][4:0]          de_regBidx,
  input  logic [WAYS-1:0][5:0]          fl_freeRegs,
  input  logic [1:0]                    haz_nDispatched,
  input  logic [WAYS-1:0]               cdb_rd_en,
  input  logic [WAYS-1:0][5:0]          cdb_rd,
  input  logic                          br_fub_pred_wrong,
  input  PHYS_WITH_READY [NUM_ARCH-2:0] bs_recov_map,
  output logic [WAYS-1:0][6:0]          mt_tagA,
  output logic [WAYS-1:0][6:0]          mt_tagB,
  output logic [WAYS-1:0][5:0]          mt_dispatchTagOld,
  output PHYS_WITH_READY [NUM_ARCH-1:0] map
);

  localparam PHYS_WITH_READY c_zero_entry = '{register: 6'd31, ready: 1'b1};

  // Only entries 0..30 are stored; the zero register is a constant.
  PHYS_WITH_READY [NUM_ARCH-2:0] r_map;
  PHYS_WITH_READY [NUM_ARCH-2:0] w_map_next;
  logic                          w_disp0;
  logic                          w_disp1;

  assign map = {c_zero_entry, r_map};

  // Value 3 on haz_nDispatched has bit 1 set, so it behaves as 2.
  assign w_disp0 = (haz_nDispatched != 2'd0);
  assign w_disp1 = haz_nDispatched[1];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_slot
      PHYS_WITH_READY w_tag_a;
      PHYS_WITH_READY w_tag_b;

      mt_lookup #(
        .FORWARD (gi != 0)
      ) u_lookup (
        .map          (map),
        .rega_idx     (de_regAidx[gi]),
        .regb_idx     (de_regBidx[gi]),
        .dest_idx     (de_destidx[gi]),
        .fwd_dest_idx (de_destidx[0]),
        .fwd_tag      (fl_freeRegs[0]),
        .cdb_rd_en    (cdb_rd_en),
        .cdb_rd       (cdb_rd),
        .tag_a        (w_tag_a),
        .tag_b        (w_tag_b),
        .tag_old      (mt_dispatchTagOld[gi])
      );

      assign mt_tagA[gi] = w_tag_a;
      assign mt_tagB[gi] = w_tag_b;
    end
  endgenerate

  // Next state: recovery source, then CDB ready-set, then dispatch writes.
  // Each later stage overrides the earlier on the same entry.
  always_comb begin
    w_map_next = br_fub_pred_wrong ? bs_recov_map : r_map;

    for (int i = 0; i < NUM_ARCH - 1; i++) begin
      if (cdb_hit(cdb_rd_en, cdb_rd, w_map_next[i].register)) w_map_next[i].ready = 1'b1;
    end

    // Loop bound stops at 30, so writes to the zero register fall away.
    if (!br_fub_pred_wrong) begin
      for (int i = 0; i < NUM_ARCH - 1; i++) begin
        if (w_disp0 && (de_destidx[0] == ARCH_REG'(i)))
          w_map_next[i] = '{register: fl_freeRegs[0], ready: 1'b0};
        if (w_disp1 && (de_destidx[1] == ARCH_REG'(i)))
          w_map_next[i] = '{register: fl_freeRegs[1], ready: 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ARCH - 1; i++) begin
        r_map[i] <= '{register: PHYS_REG'(i), ready: 1'b1};
      end
    end else begin
      r_map <= w_map_next;
    end
  end

endmodule : map_table
`default_nettype wire

// File: tb/tb_map_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_map_table
// Description : Directed self-checking testbench for map_table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_table;
  import map_table_pkg::*;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [1:0][4:0]               de_destidx;
  logic [1:0][4:0]               de_regAidx;
  logic [1:0][4:0]               de_regBidx;
  logic [1:0][5:0]               fl_freeRegs;
  logic [1:0]                    haz_nDispatched;
  logic [1:0]                    cdb_rd_en;
  logic [1:0][5:0]               cdb_rd;
  logic                          br_fub_pred_wrong;
  PHYS_WITH_READY [30:0]         bs_recov_map;
  logic [1:0][6:0]               mt_tagA;
  logic [1:0][6:0]               mt_tagB;
  logic [1:0][5:0]               mt_dispatchTagOld;
  PHYS_WITH_READY [31:0]         map;

  int n_cmp  = 0;
  int n_fail = 0;

  map_table dut (
    .clk               (clk),
    .reset             (reset),
    .de_destidx        (de_destidx),
    .de_regAidx        (de_regAidx),
    .de_regBidx        (de_regBidx),
    .fl_freeRegs       (fl_freeRegs),
    .haz_nDispatched   (haz_nDispatched),
    .cdb_rd_en         (cdb_rd_en),
    .cdb_rd            (cdb_rd),
    .br_fub_pred_wrong (br_fub_pred_wrong),
    .bs_recov_map      (bs_recov_map),
    .mt_tagA           (mt_tagA),
    .mt_tagB           (mt_tagB),
    .mt_dispatchTagOld (mt_dispatchTagOld),
    .map               (map)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] e(input int r, input bit rdy);
    return {6'(r), rdy};
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed reg=%0d rdy=%0d expected reg=%0d rdy=%0d",
             tag, obs[6:1], obs[0], exp[6:1], exp[0]);
    end
  endtask

  task automatic chk_old(input string tag, input logic [5:0] obs, input int exp);
    n_cmp++;
    assert (obs === 6'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_identity(input string tag);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s_map%0d", tag, i), map[i], e(i, 1'b1));
    end
  endtask

  // Advance through the rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    de_destidx        = '0;
    de_regAidx        = '0;
    de_regBidx        = '0;
    fl_freeRegs       = '0;
    haz_nDispatched   = 2'd0;
    cdb_rd_en         = 2'b00;
    cdb_rd            = '0;
    br_fub_pred_wrong = 1'b0;
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 31; i++) bs_recov_map[i] = '{register: PHYS_REG'(i), ready: 1'b1};
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk_identity("reset");
    @(negedge clk);
    reset = 1'b1;

    // No dispatch: old tag visible, table unchanged.
    de_destidx[0] = 5'd5;
    #1;
    chk_old("idle_old0", mt_dispatchTagOld[0], 5);
    tick();
    chk("idle_map5", map[5], e(5, 1'b1));

    // Two-wide dispatch to distinct destinations.
    @(negedge clk);
    idle_inputs();
    haz_nDispatched = 2'd2;
    de_destidx[0] = 5'd3;  de_destidx[1] = 5'd4;
    fl_freeRegs[0] = 6'd40; fl_freeRegs[1] = 6'd41;
    #1;
    chk_old("d2_old0", mt_dispatchTagOld[0], 3);
    chk_old("d2_old1", mt_dispatchTagOld[1], 4);
    tick();
    chk("d2_map3", map[3], e(40, 1'b0));
    chk("d2_map4", map[4], e(41, 1'b0));

    // Same destination in both slots; slot 1 sees slot 0's rename.
    @(negedge clk);
    idle_inputs();
    haz_nDispatched = 2'd2;
    de_destidx[0] = 5'd7;  de_destidx[1] = 5'd7;
    de_regAidx[1] = 5'd7;
    fl_freeRegs[0] = 6'd42; fl_freeRegs[1] = 6'd43;
    #1;
    chk("fwd_tagA1", mt_tagA[1], e(42, 1'b0));
    chk_old("fwd_old0", mt_dispatchTagOld[0], 7);
    chk_old("fwd_old1", mt_dispatchTagOld[1], 42);
    tick();
    chk("fwd_map7", map[7], e(43, 1'b0));

    // CDB lane 0 bypass on slot 0 source, then ready latched.
    @(negedge clk);
    idle_inputs();
    cdb_rd_en = 2'b01;  cdb_rd[0] = 6'd40;
    de_regAidx[0] = 5'd3;
    de_regBidx[0] = 5'd4;
    #1;
    chk("cdb_tagA0", mt_tagA[0], e(40, 1'b1));
    chk("cdb_tagB0", mt_tagB[0], e(41, 1'b0));
    tick();
    chk("cdb_map3", map[3], e(40, 1'b1));
    chk("cdb_map4", map[4], e(41, 1'b0));

    // CDB lane 1 bypass on slot 1 source with no forwarding match.
    @(negedge clk);
    idle_inputs();
    cdb_rd_en = 2'b10;  cdb_rd[1] = 6'd41;
    de_destidx[0] = 5'd9;
    de_regBidx[1] = 5'd4;
    #1;
    chk("cdb1_tagB1", mt_tagB[1], e(41, 1'b1));
    tick();
    chk("cdb1_map4", map[4], e(41, 1'b1));
    chk("cdb1_map7", map[7], e(43, 1'b0));

    // Mispredict: checkpoint restored, CDB applies to it, dispatch dropped.
    @(negedge clk);
    idle_inputs();
    br_fub_pred_wrong = 1'b1;
    haz_nDispatched = 2'd2;
    de_destidx[0] = 5'd10; de_destidx[1] = 5'd11;
    fl_freeRegs[0] = 6'd44; fl_freeRegs[1] = 6'd45;
    bs_recov_map[2] = '{register: 6'd50, ready: 1'b0};
    cdb_rd_en = 2'b10;  cdb_rd[1] = 6'd50;
    tick();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("recov_map%0d", i), map[i], (i == 2) ? e(50, 1'b1) : e(i, 1'b1));
    end

    // Dispatch write wins over CDB ready-set; slot 1 idle when only 1 dispatches.
    @(negedge clk);
    idle_inputs();
    haz_nDispatched = 2'd1;
    de_destidx[0] = 5'd12; de_destidx[1] = 5'd13;
    fl_freeRegs[0] = 6'd46; fl_freeRegs[1] = 6'd47;
    cdb_rd_en = 2'b01;  cdb_rd[0] = 6'd12;
    tick();
    chk("ovr_map12", map[12], e(46, 1'b0));
    chk("ovr_map13", map[13], e(13, 1'b1));

    // Zero-register destination: no forwarding, no write.
    @(negedge clk);
    idle_inputs();
    haz_nDispatched = 2'd2;
    de_destidx[0] = 5'd31; de_destidx[1] = 5'd31;
    de_regAidx[1] = 5'd31;
    fl_freeRegs[0] = 6'd47; fl_freeRegs[1] = 6'd48;
    #1;
    chk("zero_tagA1", mt_tagA[1], e(31, 1'b1));
    chk_old("zero_old1", mt_dispatchTagOld[1], 31);
    tick();
    chk("zero_map31", map[31], e(31, 1'b1));
    chk("zero_map30", map[30], e(30, 1'b1));

    // haz_nDispatched=3 behaves as two slots.
    @(negedge clk);
    idle_inputs();
    haz_nDispatched = 2'd3;
    de_destidx[0] = 5'd14; de_destidx[1] = 5'd15;
    fl_freeRegs[0] = 6'd49; fl_freeRegs[1] = 6'd51;
    tick();
    chk("n3_map14", map[14], e(49, 1'b0));
    chk("n3_map15", map[15], e(51, 1'b0));

    // Asynchronous reset mid-sequence, away from any clock edge.
    @(negedge clk);
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    chk_identity("areset");
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_map_table
`default_nettype wire
